// File: rtl/gf_log_table_gen.sv
// GF(2^8) log/exp table builder: walks powers of GENERATOR once, self-checks the
// walk, then serves single-cycle-latency lookups over a valid/ready read port.
module gf_log_table_gen #(
  parameter logic [7:0] GENERATOR = 8'h03,
  parameter logic [7:0] POLY_LOW  = 8'h1B
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       tables_valid,
  input  logic       rd_valid,
  output logic       rd_ready,
  input  logic       rd_sel,
  input  logic [7:0] rd_addr,
  output logic       rd_data_valid,
  output logic [7:0] rd_data
);

  typedef enum logic [1:0] {IDLE, GEN, CHECK, READY} state_t;

  state_t     state_q, state_d;
  logic [7:0] acc, idx;
  logic       wrap_seen;
  logic       rd_accept;
  logic [7:0] exp_mem [256];
  logic [7:0] log_mem [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? POLY_LOW : 8'h00);
    end
    return p;
  endfunction

  assign busy         = (state_q == GEN) || (state_q == CHECK);
  assign tables_valid = (state_q == READY) && !error;
  assign rd_ready     = tables_valid;
  assign rd_accept    = rd_valid && rd_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = GEN;
      GEN:     if (idx == 8'd254) state_d = CHECK;
      CHECK:   state_d = READY;
      READY:   if (start) state_d = GEN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      acc           <= 8'h01;
      idx           <= 8'h00;
      wrap_seen     <= 1'b0;
      error         <= 1'b0;
      done          <= 1'b0;
      rd_data_valid <= 1'b0;
      rd_data       <= 8'h00;
    end else begin
      state_q       <= state_d;
      done          <= (state_q == CHECK);
      rd_data_valid <= rd_accept;
      if (rd_accept) rd_data <= rd_sel ? exp_mem[rd_addr] : log_mem[rd_addr];
      unique case (state_q)
        IDLE, READY: if (start) begin
          acc       <= 8'h01;
          idx       <= 8'h00;
          wrap_seen <= 1'b0;
          error     <= 1'b0;
        end
        GEN: begin
          // Every element's order divides 255, so acc is always 1 after the
          // full walk; a short cycle is only visible as an early return to 1.
          if (idx != 8'h00 && acc == 8'h01) wrap_seen <= 1'b1;
          acc <= gf_mul(acc, GENERATOR);
          idx <= idx + 8'd1;
        end
        CHECK:   error <= (acc != 8'h01) || wrap_seen;
        default: ;
      endcase
    end
  end

  // Table storage is intentionally not reset; nothing reads it outside READY.
  always_ff @(posedge clk) begin
    if (state_q == GEN) begin
      exp_mem[idx] <= acc;
      log_mem[acc] <= idx;
    end else if (state_q == CHECK) begin
      exp_mem[255] <= 8'h01;
      log_mem[0]   <= 8'h00;
    end
  end

endmodule

// File: tb/tb_gf_log_table_gen.sv
// Directed bench for gf_log_table_gen: build timing, table contents, read port,
// non-primitive generator detection, restart handling and mid-build reset.
module tb_gf_log_table_gen;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, busy, done, error, tables_valid;
  logic       rd_valid, rd_ready, rd_sel, rd_data_valid;
  logic [7:0] rd_addr, rd_data;

  logic       start2, busy2, done2, error2, tables_valid2;
  logic       rd_valid2, rd_ready2, rd_sel2, rd_data_valid2;
  logic [7:0] rd_addr2, rd_data2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gf_log_table_gen #(.GENERATOR(8'h03), .POLY_LOW(8'h1B)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .error(error), .tables_valid(tables_valid), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .rd_sel(rd_sel), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data));

  gf_log_table_gen #(.GENERATOR(8'h02), .POLY_LOW(8'h1B)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2),
    .error(error2), .tables_valid(tables_valid2), .rd_valid(rd_valid2),
    .rd_ready(rd_ready2), .rd_sel(rd_sel2), .rd_addr(rd_addr2),
    .rd_data_valid(rd_data_valid2), .rd_data(rd_data2));

  typedef struct {
    logic       sel;
    logic [7:0] addr;
    logic [7:0] expect_data;
  } vec_t;

  vec_t vecs[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic do_read(input logic sel, input logic [7:0] addr, output logic [7:0] data,
                         output logic dv);
    rd_valid = 1'b1;
    rd_sel   = sel;
    rd_addr  = addr;
    step();
    rd_valid = 1'b0;
    data = rd_data;
    dv   = rd_data_valid;
  endtask

  // Runs a fixed window after a start edge, counting busy/done/rd_ready-low samples.
  task automatic run_build(input int hold_lo, input int hold_hi,
                           output int busy_cnt, output int done_cnt, output int nrdy_cnt);
    busy_cnt = 0; done_cnt = 0; nrdy_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (!rd_ready) nrdy_cnt++;
      start = (c >= hold_lo && c < hold_hi);
      step();
    end
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] d, l;
    logic       dv;
    int         bc, dc, nc, dv_cnt;

    vecs[0]  = '{1'b1, 8'h00, 8'h01};
    vecs[1]  = '{1'b1, 8'h01, 8'h03};
    vecs[2]  = '{1'b1, 8'h02, 8'h05};
    vecs[3]  = '{1'b1, 8'h07, 8'hFF};
    vecs[4]  = '{1'b1, 8'h08, 8'h1A};
    vecs[5]  = '{1'b1, 8'hFF, 8'h01};
    vecs[6]  = '{1'b0, 8'h01, 8'h00};
    vecs[7]  = '{1'b0, 8'h03, 8'h01};
    vecs[8]  = '{1'b0, 8'h02, 8'h19};
    vecs[9]  = '{1'b0, 8'hFF, 8'h07};
    vecs[10] = '{1'b0, 8'h00, 8'h00};

    reset_n = 1'b0; start = 1'b0; rd_valid = 1'b0; rd_sel = 1'b0; rd_addr = 8'h00;
    start2 = 1'b0; rd_valid2 = 1'b0; rd_sel2 = 1'b0; rd_addr2 = 8'h00;
    step(); step();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset error", error, 0);
    check("reset tables_valid", tables_valid, 0);
    check("reset rd_ready", rd_ready, 0);
    check("reset rd_data_valid", rd_data_valid, 0);
    check("reset rd_data", rd_data, 0);
    reset_n = 1'b1;
    step();

    // Build: busy for exactly 256 cycles, one done pulse
    start = 1'b1;
    step();
    start = 1'b0;
    run_build(-1, -1, bc, dc, nc);
    check("build busy cycles", bc, 256);
    check("build done pulses", dc, 1);
    check("build error", error, 0);
    check("build rd_ready", rd_ready, 1);
    check("build tables_valid", tables_valid, 1);

    foreach (vecs[i]) begin
      do_read(vecs[i].sel, vecs[i].addr, d, dv);
      check($sformatf("vec%0d valid", i), dv, 1);
      check($sformatf("vec%0d sel%0d addr %0h", i, vecs[i].sel, vecs[i].addr), d,
            vecs[i].expect_data);
    end

    for (int x = 1; x < 256; x++) begin
      do_read(1'b0, x[7:0], l, dv);
      do_read(1'b1, l, d, dv);
      check($sformatf("exp[log[%0h]]", x), d, x);
    end

    // Back-to-back requests then hold of last result
    rd_valid = 1'b1; rd_sel = 1'b1;
    rd_addr = 8'h01; step();
    check("b2b0 valid", rd_data_valid, 1); check("b2b0 data", rd_data, 8'h03);
    rd_addr = 8'h02; step();
    check("b2b1 valid", rd_data_valid, 1); check("b2b1 data", rd_data, 8'h05);
    rd_addr = 8'h03; step();
    check("b2b2 valid", rd_data_valid, 1); check("b2b2 data", rd_data, 8'h0F);
    rd_valid = 1'b0; step();
    check("hold valid", rd_data_valid, 0); check("hold data", rd_data, 8'h0F);

    // Non-primitive generator: error flagged, port never serves
    start2 = 1'b1; step(); start2 = 1'b0;
    for (int c = 0; c < 300; c++) step();
    check("gen02 error", error2, 1);
    check("gen02 rd_ready", rd_ready2, 0);
    check("gen02 tables_valid", tables_valid2, 0);
    dv_cnt = 0;
    rd_valid2 = 1'b1; rd_sel2 = 1'b1; rd_addr2 = 8'h01;
    for (int c = 0; c < 6; c++) begin
      step();
      if (rd_data_valid2) dv_cnt++;
    end
    rd_valid2 = 1'b0;
    check("gen02 data_valid count", dv_cnt, 0);

    // Rebuild from READY with a concurrent request, start held mid-GEN
    rd_valid = 1'b1; rd_sel = 1'b1; rd_addr = 8'h02; start = 1'b1;
    step();
    rd_valid = 1'b0; start = 1'b0;
    check("restart req valid", rd_data_valid, 1);
    check("restart req data", rd_data, 8'h05);
    run_build(20, 30, bc, dc, nc);
    check("rebuild busy cycles", bc, 256);
    check("rebuild done pulses", dc, 1);
    check("rebuild rd_ready low cycles", nc, 256);
    check("rebuild rd_ready", rd_ready, 1);
    do_read(1'b1, 8'h09, d, dv);
    check("rebuild exp[09]", d, 8'h2E);

    // Reset mid-build acts immediately, without a clock edge
    start = 1'b1; step(); start = 1'b0;
    for (int c = 0; c < 100; c++) step();
    check("midbuild busy", busy, 1);
    reset_n = 1'b0;
    #2;
    check("async busy", busy, 0);
    check("async done", done, 0);
    check("async error", error, 0);
    check("async rd_ready", rd_ready, 0);
    check("async rd_data_valid", rd_data_valid, 0);
    check("async rd_data", rd_data, 0);
    step();
    reset_n = 1'b1;
    step();
    start = 1'b1; step(); start = 1'b0;
    run_build(-1, -1, bc, dc, nc);
    check("post-reset busy cycles", bc, 256);
    check("post-reset error", error, 0);
    check("post-reset rd_ready", rd_ready, 1);
    do_read(1'b0, 8'h1A, d, dv);
    check("post-reset log[1A]", d, 8'h08);
    do_read(1'b1, 8'h06, d, dv);
    check("post-reset exp[06]", d, 8'h55);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
